// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl_pkg : shared hazard-controller types/constants |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_e;

   localparam int MULDIV_CYCLES_DEF = 4;
   localparam int STALL_CNT_W       = 16;
   localparam int MD_CNT_W          = 4;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : saturating up-counter with synchronous clear         |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Clear beats increment; the all-ones value is sticky until cleared.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl : stall/flush generation for 5-stage pipeline |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_W         = 4,
   parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [REG_W-1:0]       id_rs1,
   input  logic [REG_W-1:0]       id_rs2,
   input  logic                   id_use_rs1,
   input  logic                   id_use_rs2,
   input  logic [REG_W-1:0]       ex_rd,
   input  logic                   ex_is_load,
   input  logic                   ex_muldiv,
   input  logic                   ex_branch_taken,
   input  logic                   mem_busy,
   input  logic                   flush_req,
   input  logic                   clr_stats,
   output logic                   pc_dis,
   output logic                   ifid_dis,
   output logic                   idex_dis,
   output logic                   exmem_dis,
   output logic                   memwb_dis,
   output logic                   ifid_flush,
   output logic                   idex_flush,
   output logic                   exmem_flush,
   output logic                   md_done,
   output logic [STALL_CNT_W-1:0] stall_count
);

   // cnt holds the remaining stall cycles after the first one taken in IDLE.
   localparam bit                  MD_MULTI = (MULDIV_CYCLES > 1);
   localparam logic [MD_CNT_W-1:0] MD_INIT  =
      MD_CNT_W'((MULDIV_CYCLES > 1) ? (MULDIV_CYCLES - 2) : 0);

   hz_state_e           state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic                load_use;

   assign load_use = ex_is_load &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_dis      = 1'b0;
      ifid_dis    = 1'b0;
      idex_dis    = 1'b0;
      exmem_dis   = 1'b0;
      memwb_dis   = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      md_done     = 1'b0;

      if (!rst_n) begin
         // Keep every buffer clearing for as long as reset is held.
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (flush_req) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         state_d     = IDLE;
         cnt_d       = '0;
      end else if (mem_busy) begin
         pc_dis    = 1'b1;
         ifid_dis  = 1'b1;
         idex_dis  = 1'b1;
         exmem_dis = 1'b1;
         memwb_dis = 1'b1;
      end else if (state_q == MD_BUSY) begin
         if (cnt_q != '0) begin
            pc_dis      = 1'b1;
            ifid_dis    = 1'b1;
            idex_dis    = 1'b1;
            exmem_flush = 1'b1;
            cnt_d       = cnt_q - 1'b1;
         end else begin
            md_done = 1'b1;
            state_d = IDLE;
         end
      end else if (ex_muldiv) begin
         if (MD_MULTI) begin
            pc_dis      = 1'b1;
            ifid_dis    = 1'b1;
            idex_dis    = 1'b1;
            exmem_flush = 1'b1;
            cnt_d       = MD_INIT;
            state_d     = MD_BUSY;
         end else begin
            md_done = 1'b1;
         end
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_dis     = 1'b1;
         ifid_dis   = 1'b1;
         idex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   sat_counter #(
      .WIDTH (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_stats),
      .en    (pc_dis),
      .count (stall_count)
   );

endmodule
`default_nettype wire
